// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
//   Round-robin arbiter that shares a single 3-to-8 one-hot select path
//   among 8 requesters. The winning index and the grant-valid flag are
//   registered, and the one-hot grant is decoded from that registered state.
//   A holder keeps the grant until it drops its request. When the optional
//   timeout is built in, a holder can also be pre-empted.
//
// Build option
//   ARB_TIMEOUT_EN  when defined, a holder that has kept the grant for
//                   MAX_HOLD cycles is pre-empted if anyone else is waiting.
//                   When undefined, preempt is tied low and no hold counter
//                   exists.
//
// Parameters
//   MAX_HOLD  consecutive grant cycles before pre-emption (2..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   arb_en     1 allows new grants to be issued
//   req[7:0]   level-sensitive requests, bit i = requester i
//   grant_vld  a grant is active (registered)
//   grant_idx  binary index of the current holder (registered)
//   grant_oh   one-hot of grant_idx, all zero when grant_vld is 0
//   preempt    one-cycle pulse when a grant is revoked by timeout
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [7:0] req,
  output logic       grant_vld,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_oh,
  output logic       preempt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic       vld_nxt;
  logic [7:0] holder_bit;
  logic [7:0] others;
  logic       holder_req;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             preempt_nxt;
`endif

  // Reject configurations where the hold counter cannot reach MAX_HOLD-1.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_decoder_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  // Return the first index with its mask bit set, scanning from start
  // upward and wrapping modulo 8.
  function automatic logic [2:0] pick(input logic [2:0] start, input logic [7:0] mask);
    logic [2:0] cand;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = start + 3'(k);
      if (!found && mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  endfunction

  assign holder_bit = 8'h01 << grant_idx;
  assign others     = req & ~holder_bit;
  assign holder_req = req[grant_idx];

  // The grant is decoded from registered state only, so it cannot glitch.
  assign grant_oh = grant_vld ? holder_bit : 8'h00;

`ifndef ARB_TIMEOUT_EN
  assign preempt = 1'b0;
`endif

  // Next-state logic. On a release the scan begins at holder+1. Because
  // the releasing holder has its request bit low at that edge, it can never
  // be picked again immediately.
  always_comb begin
    state_nxt = state;
    idx_nxt   = grant_idx;
    vld_nxt   = grant_vld;
    ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_nxt = hold_cnt;
    preempt_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (arb_en && (|req)) begin
          idx_nxt   = pick(ptr, req);
          vld_nxt   = 1'b1;
          state_nxt = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      BUSY: begin
        if (!holder_req) begin
          ptr_nxt = grant_idx + 3'd1;
          if (arb_en && (|others)) begin
            idx_nxt = pick(grant_idx + 3'd1, req);
`ifdef ARB_TIMEOUT_EN
            hold_cnt_nxt = '0;
`endif
          end else begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          // At the timeout point the counter restarts whether or not
          // anyone else is waiting. The holder loses the grant only when
          // there is another requester.
          if (arb_en && (hold_cnt == CNT_W'(MAX_HOLD - 1))) begin
            hold_cnt_nxt = '0;
            if (|others) begin
              preempt_nxt = 1'b1;
              idx_nxt     = pick(grant_idx + 3'd1, others);
              ptr_nxt     = grant_idx + 3'd1;
            end
          end else if (hold_cnt != {CNT_W{1'b1}}) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // State register. Reset takes priority over any grant in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_vld <= 1'b0;
      grant_idx <= 3'd0;
      ptr       <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      preempt   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      grant_vld <= vld_nxt;
      grant_idx <= idx_nxt;
      ptr       <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= hold_cnt_nxt;
      preempt   <= preempt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb_rr_decoder_arbiter
//   Scoreboard bench for rr_decoder_arbiter. The stimulus driver advances a
//   behavioural model of the arbitration rules for each cycle and queues the
//   expected outputs. An independent monitor pops one entry after every
//   rising edge and compares it with the DUT outputs.
module tb_rr_decoder_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 16;
`endif
  localparam int TB_CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       grant_vld;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       preempt;

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state. m_holder is -1 when nobody holds the grant.
  int m_holder = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_pre = 0;

  rr_decoder_arbiter #(
    .MAX_HOLD(TB_MAX_HOLD),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arb_en(arb_en),
    .req(req),
    .grant_vld(grant_vld),
    .grant_idx(grant_idx),
    .grant_oh(grant_oh),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Round-robin choice: the first requester found when counting upward
  // from start, wrapping around at 8.
  function automatic int pick_ref(input int start, input logic [7:0] mask);
    for (int k = 0; k < 8; k++) begin
      if (mask[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and queue the outputs
  // the DUT must show after the next rising edge.
  task automatic applyStimulus(input logic r, input logic en, input logic [7:0] rq);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    arb_en = en;
    req    = rq;
    m_pre  = 0;
    if (!r) begin
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
    end else if (m_holder < 0) begin
      if (en && rq != 8'h00) begin
        m_holder = pick_ref(m_ptr, rq);
        m_cnt    = 0;
      end
    end else if (!rq[m_holder]) begin
      m_ptr = (m_holder + 1) % 8;
      if (en && rq != 8'h00) begin
        m_holder = pick_ref(m_ptr, rq);
        m_cnt    = 0;
      end else begin
        m_holder = -1;
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (en && m_cnt == TB_MAX_HOLD - 1) begin
        logic [7:0] rest;
        rest  = rq;
        rest[m_holder] = 1'b0;
        m_cnt = 0;
        if (rest != 8'h00) begin
          m_pre    = 1;
          m_ptr    = (m_holder + 1) % 8;
          m_holder = pick_ref(m_ptr, rest);
        end
      end else if (m_cnt < (1 << TB_CNT_W) - 1) begin
        m_cnt++;
      end
`endif
    end
    e.vld = (m_holder >= 0);
    e.idx = (m_holder >= 0) ? 3'(m_holder) : 3'd0;
    e.oh  = (m_holder >= 0) ? 8'(1 << m_holder) : 8'h00;
    e.pre = (m_pre != 0);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("grant_vld", {7'd0, grant_vld}, {7'd0, e.vld});
        checkOutput("grant_oh", grant_oh, e.oh);
        checkOutput("preempt", {7'd0, preempt}, {7'd0, e.pre});
        if (e.vld) checkOutput("grant_idx", {5'd0, grant_idx}, {5'd0, e.idx});
      end
    end
  end

  // Directed scenarios, followed by random traffic.
  initial begin
    logic [7:0] cur;
    int         holder;

    // Reset asserted while all requesters are active, then the first grant.
    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);

    // Single requester: grant, then release.
    repeat (3) applyStimulus(1'b1, 1'b1, 8'h20);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h00);

    // Fairness between requesters 0 and 7, handing off back-to-back.
    applyStimulus(1'b0, 1'b1, 8'h81);
    applyStimulus(1'b1, 1'b1, 8'h81);
    holder = 0;
    for (int r = 0; r < 4; r++) begin
      repeat (2) applyStimulus(1'b1, 1'b1, 8'h81);
      applyStimulus(1'b1, 1'b1, 8'h81 & ~(8'h01 << holder));
      holder = 7 - holder;
    end
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h00);

    // Holder 6 releases while arb_en=0; the wrapped scan 7,0,1 picks 1.
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h40);
    applyStimulus(1'b1, 1'b0, 8'h02);
    applyStimulus(1'b1, 1'b0, 8'h42);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h42);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h00);

    // Reset in the middle of a grant to requester 3.
    repeat (3) applyStimulus(1'b1, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h08);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h18);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h00);

    // Constant pair of requests, then a lone requester.
    repeat (20) applyStimulus(1'b1, 1'b1, 8'h03);
    repeat (10) applyStimulus(1'b1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h03);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h00);

    // Random traffic. Requests tend to persist so that holds last long
    // enough to reach the timeout.
    cur = 8'h00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) >= 75) cur = 8'($urandom) & 8'($urandom);
      applyStimulus($urandom_range(99) >= 2, $urandom_range(99) >= 15, cur);
    end

    repeat (3) @(negedge clk);
    checkOutput("drain", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
